// File: rtl/data_memory.sv
// Byte-addressed big-endian data memory: one pipelined read port, NUM_WR_PORTS write ports,
// byte/half/word accesses with load extension, and a post-reset clear engine.
module data_memory #(
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_WR_PORTS = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  output logic                           o_ready,
  input  logic                           i_r_req,
  input  logic [31:0]                    i_r_addr,
  input  logic [1:0]                     i_r_size,
  input  logic                           i_r_unsigned,
  output logic                           o_r_valid,
  output logic [31:0]                    o_r_data,
  output logic                           o_r_misaligned,
  input  logic [NUM_WR_PORTS-1:0]        i_w_en,
  input  logic [NUM_WR_PORTS-1:0][31:0]  i_w_addr,
  input  logic [NUM_WR_PORTS-1:0][31:0]  i_w_data,
  input  logic [NUM_WR_PORTS-1:0][1:0]   i_w_size,
  output logic [NUM_WR_PORTS-1:0]        o_w_misaligned
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_WORDS = DEPTH / 4;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = (lo[0] == 1'b0);
      SIZE_WORD: is_aligned = (lo == 2'b00);
      default:   is_aligned = 1'b0;
    endcase
  endfunction

  logic [7:0]                                mem [DEPTH];
  logic [0:0]                                state_r;
  logic [ADDR_WIDTH-1:0]                     clr_idx_r;
  logic [ADDR_WIDTH-1:0]                     clr_base_s;
  logic [ADDR_WIDTH-1:0]                     r_base_s;
  logic                                      r_ok_s;
  logic [7:0]                                rb0_s, rb1_s, rb2_s, rb3_s;
  logic [31:0]                               load_s;
  logic [NUM_WR_PORTS-1:0]                   w_ok_s;
  logic [NUM_WR_PORTS-1:0][ADDR_WIDTH-1:0]   w_base_s;
  logic                                      unused_s;

  assign o_ready    = (state_r == ST_RUN);
  assign clr_base_s = clr_idx_r << 2;

  // Read address decode and big-endian load assembly with extension.
  always_comb begin
    r_base_s = i_r_addr[ADDR_WIDTH-1:0];
    r_ok_s   = is_aligned(i_r_size, i_r_addr[1:0]);
    rb0_s    = mem[r_base_s];
    rb1_s    = mem[r_base_s + ADDR_WIDTH'(1)];
    rb2_s    = mem[r_base_s + ADDR_WIDTH'(2)];
    rb3_s    = mem[r_base_s + ADDR_WIDTH'(3)];
    case (i_r_size)
      SIZE_BYTE: begin
        if (i_r_unsigned) begin
          load_s = {24'h000000, rb0_s};
        end else begin
          load_s = {{24{rb0_s[7]}}, rb0_s};
        end
      end
      SIZE_HALF: begin
        if (i_r_unsigned) begin
          load_s = {16'h0000, rb0_s, rb1_s};
        end else begin
          load_s = {{16{rb0_s[7]}}, rb0_s, rb1_s};
        end
      end
      SIZE_WORD: load_s = {rb0_s, rb1_s, rb2_s, rb3_s};
      default:   load_s = 32'h00000000;
    endcase
  end

  // Per-port write qualification; high address bits are deliberately dropped.
  always_comb begin
    unused_s = ^i_r_addr[31:ADDR_WIDTH];
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      w_base_s[p] = i_w_addr[p][ADDR_WIDTH-1:0];
      w_ok_s[p]   = i_w_en[p] && is_aligned(i_w_size[p], i_w_addr[p][1:0]);
      unused_s    = unused_s ^ (^i_w_addr[p][31:ADDR_WIDTH]);
    end
  end

  // Clear/run sequencing and registered read/flag outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r        <= ST_CLEAR;
      clr_idx_r      <= {ADDR_WIDTH{1'b0}};
      o_r_valid      <= 1'b0;
      o_r_data       <= 32'h00000000;
      o_r_misaligned <= 1'b0;
      o_w_misaligned <= {NUM_WR_PORTS{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_idx_r      <= clr_idx_r + ADDR_WIDTH'(1);
          o_r_valid      <= 1'b0;
          o_r_data       <= 32'h00000000;
          o_r_misaligned <= 1'b0;
          o_w_misaligned <= {NUM_WR_PORTS{1'b0}};
          if (clr_idx_r == LAST_WORD) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          o_r_valid      <= i_r_req;
          o_r_misaligned <= i_r_req && !r_ok_s;
          o_r_data       <= (i_r_req && r_ok_s) ? load_s : 32'h00000000;
          o_w_misaligned <= i_w_en & ~w_ok_s;
        end
        default: state_r <= ST_CLEAR;
      endcase
    end
  end

  // Storage: clear engine zeroes a word per edge; in RUN later ports overwrite earlier ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_r == ST_CLEAR) begin
        for (int k = 0; k < 4; k++) begin
          mem[clr_base_s + ADDR_WIDTH'(k)] <= 8'h00;
        end
      end else begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (w_ok_s[p]) begin
            case (i_w_size[p])
              SIZE_WORD: begin
                mem[w_base_s[p]]                  <= i_w_data[p][31:24];
                mem[w_base_s[p] + ADDR_WIDTH'(1)] <= i_w_data[p][23:16];
                mem[w_base_s[p] + ADDR_WIDTH'(2)] <= i_w_data[p][15:8];
                mem[w_base_s[p] + ADDR_WIDTH'(3)] <= i_w_data[p][7:0];
              end
              SIZE_HALF: begin
                mem[w_base_s[p]]                  <= i_w_data[p][15:8];
                mem[w_base_s[p] + ADDR_WIDTH'(1)] <= i_w_data[p][7:0];
              end
              SIZE_BYTE: mem[w_base_s[p]] <= i_w_data[p][7:0];
              default: begin
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected read responses and write
// misalignment pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_data_memory;
  localparam int AW = 8;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready;
  logic r_req = 1'b0;
  logic [31:0] r_addr = 32'h0;
  logic [1:0] r_size = 2'b00;
  logic r_unsigned = 1'b0;
  logic r_valid;
  logic [31:0] r_data;
  logic r_mis;
  logic [NP-1:0] w_en = '0;
  logic [NP-1:0][31:0] w_addr = '0;
  logic [NP-1:0][31:0] w_data = '0;
  logic [NP-1:0][1:0] w_size = '0;
  logic [NP-1:0] w_mis;

  always #5 clk = ~clk;

  data_memory #(.ADDR_WIDTH(AW), .NUM_WR_PORTS(NP)) dut (
    .i_clk(clk), .i_rst(rst), .o_ready(ready),
    .i_r_req(r_req), .i_r_addr(r_addr), .i_r_size(r_size), .i_r_unsigned(r_unsigned),
    .o_r_valid(r_valid), .o_r_data(r_data), .o_r_misaligned(r_mis),
    .i_w_en(w_en), .i_w_addr(w_addr), .i_w_data(w_data), .i_w_size(w_size),
    .o_w_misaligned(w_mis)
  );

  typedef struct {
    logic [31:0] data;
    logic        mis;
    string       nm;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic [NP-1:0] wm_q[$];
  logic [NP-1:0] wmis_pend = '0;
  int total = 0;
  int passed = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Monitor: compare every presented read response and write-misalignment pulse.
  always @(negedge clk) begin
    rd_exp_t e;
    if (r_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_read: got data %h mis %b expected no response", r_data, r_mis);
      end else begin
        e = rd_q.pop_front();
        check({e.nm, "_data"}, r_data, e.data);
        check({e.nm, "_mis"}, {31'h0, r_mis}, {31'h0, e.mis});
      end
    end else if (r_data !== 32'h0 || r_mis !== 1'b0) begin
      total++;
      $display("FAIL idle_read_outputs: got data %h mis %b expected 0", r_data, r_mis);
    end
    if (w_mis !== '0) begin
      if (wm_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_wmis: got %b expected 00", w_mis);
      end else begin
        check("w_misaligned", {30'h0, w_mis}, {30'h0, wm_q.pop_front()});
      end
    end
  end

  task automatic rd(input logic [31:0] a, input logic [1:0] s, input logic u,
                    input logic [31:0] exp, input logic mis, input string nm);
    rd_exp_t x;
    r_req = 1'b1; r_addr = a; r_size = s; r_unsigned = u;
    x.data = exp; x.mis = mis; x.nm = nm;
    rd_q.push_back(x);
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] s, input logic mis);
    w_en[p] = 1'b1; w_addr[p] = a; w_data[p] = d; w_size[p] = s;
    if (mis) wmis_pend[p] = 1'b1;
  endtask

  task automatic tick();
    if (wmis_pend != '0) wm_q.push_back(wmis_pend);
    wmis_pend = '0;
    @(posedge clk);
    #1;
    r_req = 1'b0;
    w_en = '0;
  endtask

  // Counts edges after reset release until ready; optionally pokes traffic during CLEAR.
  task automatic wait_ready(input logic poke, output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      if (poke && i <= 5) begin
        w_en = 2'b11;
        w_addr[0] = 32'h0; w_data[0] = 32'hDEADBEEF; w_size[0] = 2'b10;
        w_addr[1] = 32'h5; w_data[1] = 32'h1234; w_size[1] = 2'b01;
        r_req = 1'b1; r_addr = 32'h0; r_size = 2'b10;
      end
      @(posedge clk);
      #1;
      r_req = 1'b0;
      w_en = '0;
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_r_valid", {31'h0, r_valid}, 32'h0);
    check("rst_r_data", r_data, 32'h0);
    check("rst_r_mis", {31'h0, r_mis}, 32'h0);
    check("rst_w_mis", {30'h0, w_mis}, 32'h0);
    rst = 1'b0;
    wait_ready(1'b0, n);
    check("ready_edges", n, 32'd64);

    rd(32'h00, 2'b10, 1'b0, 32'h0, 1'b0, "clr_00"); tick();
    rd(32'h7C, 2'b10, 1'b0, 32'h0, 1'b0, "clr_7c"); tick();
    rd(32'hFC, 2'b10, 1'b0, 32'h0, 1'b0, "clr_fc"); tick();

    wr(0, 32'h10, 32'h80FF1234, 2'b10, 1'b0); tick();
    rd(32'h10, 2'b10, 1'b0, 32'h80FF1234, 1'b0, "word_10"); tick();
    rd(32'h10, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, "byte_10_s"); tick();
    rd(32'h10, 2'b00, 1'b1, 32'h00000080, 1'b0, "byte_10_u"); tick();
    rd(32'h12, 2'b01, 1'b0, 32'h00001234, 1'b0, "half_12_s"); tick();
    rd(32'h10, 2'b01, 1'b0, 32'hFFFF80FF, 1'b0, "half_10_s"); tick();
    rd(32'h10, 2'b01, 1'b1, 32'h000080FF, 1'b0, "half_10_u"); tick();
    rd(32'h13, 2'b00, 1'b0, 32'h00000034, 1'b0, "byte_13_s"); tick();
    rd(32'hFFFF_FF10, 2'b10, 1'b1, 32'h80FF1234, 1'b0, "word_hiaddr"); tick();

    wr(0, 32'h20, 32'hAAAAAAAA, 2'b10, 1'b0);
    wr(1, 32'h21, 32'h00000055, 2'b00, 1'b0); tick();
    rd(32'h20, 2'b10, 1'b0, 32'hAA55AAAA, 1'b0, "overlap_20"); tick();
    wr(0, 32'h24, 32'h01020304, 2'b10, 1'b0);
    wr(1, 32'h26, 32'h0000BEEF, 2'b01, 1'b0); tick();
    rd(32'h24, 2'b10, 1'b0, 32'h0102BEEF, 1'b0, "overlap_24"); tick();
    wr(0, 32'h28, 32'h00000011, 2'b00, 1'b0);
    wr(1, 32'h28, 32'h00000022, 2'b00, 1'b0); tick();
    rd(32'h28, 2'b00, 1'b1, 32'h00000022, 1'b0, "same_byte_28"); tick();

    wr(0, 32'h31, 32'hCAFEF00D, 2'b01, 1'b1); tick();
    rd(32'h30, 2'b10, 1'b0, 32'h0, 1'b0, "mis_w_unchanged"); tick();
    rd(32'h02, 2'b10, 1'b0, 32'h0, 1'b1, "mis_word_02"); tick();
    rd(32'h00, 2'b11, 1'b0, 32'h0, 1'b1, "mis_size11"); tick();
    wr(1, 32'h42, 32'h99999999, 2'b10, 1'b1); tick();

    wr(0, 32'h40, 32'h11111111, 2'b10, 1'b0); tick();
    wr(0, 32'h40, 32'h22222222, 2'b10, 1'b0);
    rd(32'h40, 2'b10, 1'b0, 32'h11111111, 1'b0, "rd_old_40"); tick();
    rd(32'h40, 2'b10, 1'b0, 32'h22222222, 1'b0, "rd_new_40"); tick();
    tick();

    rst = 1'b1; tick();
    rst = 1'b0;
    check("ready_drop", {31'h0, ready}, 32'h0);
    repeat (10) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    wait_ready(1'b1, n);
    check("ready_edges_restart", n, 32'd64);
    rd(32'h00, 2'b10, 1'b0, 32'h0, 1'b0, "post_clr_00"); tick();
    rd(32'h10, 2'b10, 1'b0, 32'h0, 1'b0, "post_clr_10"); tick();
    rd(32'h40, 2'b10, 1'b0, 32'h0, 1'b0, "post_clr_40"); tick();

    for (int i = 0; i < 10 && (rd_q.size() != 0 || wm_q.size() != 0); i++) tick();
    tick();
    check("rd_queue_drained", rd_q.size(), 32'd0);
    check("wmis_queue_drained", wm_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
